// File: rtl/somador_serial_param.sv
// Purpose : digit-serial adder/subtractor that reuses one DIGIT-bit ripple slice.
// Latency : NDIG+1 edges from the start edge to the done pulse.
// Backpres: start is ignored while busy; S/flags hold until the next result.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   start, sub, A, B,   request and operands, sampled together while idle
//   Cin                 carry-in (add) or borrow-in (subtract)
//   S, Cout, overflow,  result and flags, updated only on the last-digit edge
//   zero
//   busy, done          high while processing / one-cycle result-valid pulse
module somador_serial_param #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  // A partial last digit would need a different slice width; refuse it.
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("somador_serial_param: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, nstate;
  logic [WIDTH-1:0]  a, b, r;
  logic              c;
  logic [CW-1:0]     cnt;
  logic [DIGIT:0]    slice;
  logic [WIDTH+DIGIT-1:0] rcat;
  logic [WIDTH-1:0]  r_next;
  logic              msb_cin;
  logic              last;

  // One ripple slice: DIGIT LSBs of each operand plus the running carry.
  assign slice = {1'b0, a[DIGIT-1:0]} + {1'b0, b[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};

  // New digit enters at the MSB end; the concatenation keeps DIGIT == WIDTH legal.
  assign rcat   = {slice[DIGIT-1:0], r};
  assign r_next = rcat[WIDTH+DIGIT-1:DIGIT];

  // Carry into the slice MSB recovered from its sum bit: s = a ^ b ^ cin.
  assign msb_cin = a[DIGIT-1] ^ b[DIGIT-1] ^ slice[DIGIT-1];

  assign last = (cnt == LAST);
  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (last)  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      r        <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      S        <= '0;
      Cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract as A + ~B + ~Cin, i.e. A - B - Cin.
            a   <= A;
            b   <= sub ? ~B : B;
            c   <= sub ? ~Cin : Cin;
            cnt <= '0;
            r   <= '0;
          end
        end
        RUN: begin
          a   <= a >> DIGIT;
          b   <= b >> DIGIT;
          r   <= r_next;
          c   <= slice[DIGIT];
          cnt <= cnt + CW'(1);
          if (last) begin
            S        <= r_next;
            Cout     <= slice[DIGIT];
            overflow <= msb_cin ^ slice[DIGIT];
            zero     <= (r_next == '0);
            done     <= 1'b1;
            cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial_param.sv
module tb_somador_serial_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  // WIDTH=16, DIGIT=4
  logic        st16, sub16, cin16, co16, ov16, z16, bz16, dn16;
  logic [15:0] a16, b16, s16;
  // WIDTH=8, DIGIT=8
  logic        st8, sub8, cin8, co8, ov8, z8, bz8, dn8;
  logic [7:0]  a8, b8, s8;
  // WIDTH=12, DIGIT=3
  logic        st12, sub12, cin12, co12, ov12, z12, bz12, dn12;
  logic [11:0] a12, b12, s12;

  somador_serial_param #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .sub(sub16), .A(a16), .B(b16), .Cin(cin16),
    .S(s16), .Cout(co16), .overflow(ov16), .zero(z16), .busy(bz16), .done(dn16));

  somador_serial_param #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub8), .A(a8), .B(b8), .Cin(cin8),
    .S(s8), .Cout(co8), .overflow(ov8), .zero(z8), .busy(bz8), .done(dn8));

  somador_serial_param #(.WIDTH(12), .DIGIT(3)) dut12 (
    .clk(clk), .rst(rst), .start(st12), .sub(sub12), .A(a12), .B(b12), .Cin(cin12),
    .S(s12), .Cout(co12), .overflow(ov12), .zero(z12), .busy(bz12), .done(dn12));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation on the 16-bit instance from the current cycle and
  // leaves the bench sitting in the done cycle.
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic ci, input logic [15:0] es,
                      input logic ec, input logic ev, input logic ez);
    int nb;
    a16 = a; b16 = b; sub16 = s; cin16 = ci; st16 = 1'b1;
    tick();
    st16 = 1'b0;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (bz16 && !dn16) nb++;
      tick();
    end
    chk({tag, ".busycycles"}, 16'(nb), 16'd4);
    chk({tag, ".done_busy"}, {14'b0, dn16, bz16}, 16'b10);
    chk({tag, ".S"}, s16, es);
    chk({tag, ".flags"}, {13'b0, co16, ov16, z16}, {13'b0, ec, ev, ez});
  endtask

  initial begin
    int nd;
    int ua, ub, sa, sb, u, sr, k;
    logic [11:0] ra, rb, es;
    logic        rs, rc, ec, ev, ez;

    rst = 1'b1;
    st16 = 0; sub16 = 0; cin16 = 0; a16 = '0; b16 = '0;
    st8  = 0; sub8  = 0; cin8  = 0; a8  = '0; b8  = '0;
    st12 = 0; sub12 = 0; cin12 = 0; a12 = '0; b12 = '0;
    tick();
    tick();
    chk("reset.S", s16, 16'h0000);
    chk("reset.flags", {11'b0, co16, ov16, z16, bz16, dn16}, 16'b00100);
    rst = 1'b0;
    tick();

    op16("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    tick();
    chk("add1234.single_done", {15'b0, dn16}, 16'd0);

    op16("addFFFF", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    op16("b2b7FFF", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    tick();

    op16("sub5m7", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op16("sub8000m1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    tick();
    chk("sub.single_done", {15'b0, dn16}, 16'd0);

    // Second start in cycle 2 must be ignored.
    a16 = 16'h1111; b16 = 16'h1111; sub16 = 1'b0; cin16 = 1'b0; st16 = 1'b1;
    tick();
    st16 = 1'b0;
    tick();
    a16 = 16'hFFFF; st16 = 1'b1;
    tick();
    st16 = 1'b0;
    tick();
    chk("ignore.S_held", s16, 16'h7FFF);
    tick();
    chk("ignore.done", {15'b0, dn16}, 16'd1);
    chk("ignore.S", s16, 16'h2222);
    tick();

    // Reset in cycle 3 of a run discards it.
    a16 = 16'h1234; b16 = 16'h0001; st16 = 1'b1;
    tick();
    st16 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst.S", s16, 16'h0000);
    chk("midrst.flags", {11'b0, co16, ov16, z16, bz16, dn16}, 16'b00100);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dn16 || bz16) nd++;
    end
    chk("midrst.no_done", 16'(nd), 16'd0);

    // Single-digit configuration: done two edges after start.
    a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; cin8 = 1'b1; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    chk("w8.cycle1", {14'b0, dn8, bz8}, 16'b01);
    tick();
    chk("w8.cycle2", {14'b0, dn8, bz8}, 16'b10);
    chk("w8.S", {8'b0, s8}, 16'h0001);
    chk("w8.flags", {13'b0, co8, ov8, z8}, 16'b110);
    tick();

    // Randomised operations on WIDTH=12, DIGIT=3 against integer arithmetic.
    for (int n = 0; n < 1000; n++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      ua = int'(ra);
      ub = int'(rb);
      sa = ra[11] ? ua - 4096 : ua;
      sb = rb[11] ? ub - 4096 : ub;
      if (rs) begin
        u  = ua - ub - int'(rc);
        sr = sa - sb - int'(rc);
        ec = (ua >= ub + int'(rc));
      end else begin
        u  = ua + ub + int'(rc);
        sr = sa + sb + int'(rc);
        ec = (u >= 4096);
      end
      es = u[11:0];
      ev = (sr > 2047) || (sr < -2048);
      ez = (es == 12'd0);

      a12 = ra; b12 = rb; sub12 = rs; cin12 = rc; st12 = 1'b1;
      tick();
      st12 = 1'b0;
      k = 1;
      while (!dn12 && k < 12) begin
        tick();
        k++;
      end
      chk("r12.latency", 16'(k), 16'd5);
      chk("r12.S", {4'b0, s12}, {4'b0, es});
      chk("r12.flags", {13'b0, co12, ov12, z12}, {13'b0, ec, ev, ez});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/somador_serial_param.md
# somador_serial_param

Parametrised digit-serial adder/subtractor, the multi-cycle successor of the fixed 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, reusing one DIGIT-bit ripple slice. It sits between operand registers and the datapath result bus, with a start/busy/done handshake and carry, overflow and zero flags.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of DIGIT. Elaboration fails otherwise.
- DIGIT, 4, bits processed per clock. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- Cin  input  1  carry-in (add) or borrow-in (subtract); sampled with start.
- S  output  WIDTH  result; held from done until the next accepted start.
- Cout  output  1  raw carry-out of the MSB digit. When sub=1, borrow-out = ~Cout.
- overflow  output  1  two's-complement overflow of the operation.
- zero  output  1  1 when S == 0.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when the result is valid.

## Operation
- States: IDLE, RUN.
- IDLE, start=1:
  - Latch A into the shift register a.
  - Latch b = sub ? ~B : B.
  - Latch carry c = sub ? ~Cin : Cin.
  - Clear the digit counter and the result shift register.
  - Go to RUN.
  - Subtract therefore computes A − B − Cin.
- RUN, each clock:
  - Add the DIGIT LSBs of a and b, plus c.
  - Shift the DIGIT-bit sum into the MSB end of the result register (right-shift); right-shift a and b by DIGIT.
  - Register the slice carry-out into c.
  - Increment the counter.
- Last digit (counter = NDIG−1), at that clock edge:
  - Copy the final result to S and the carry-out to Cout.
  - overflow = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
  - zero = (S == 0).
  - Assert done for the next cycle; return to IDLE.
- start while busy=1 is ignored; sub, A, B and Cin are not re-sampled.
- S, Cout, overflow and zero change only at the last-digit edge. They hold through later IDLE cycles and through the next operation's RUN.
- Reset, asynchronous and valid at any time including mid-RUN:
  - state = IDLE, counter = 0, internal registers = 0.
  - S = 0, Cout = 0, overflow = 0, zero = 1, busy = 0, done = 0.
  - An interrupted operation is discarded; no done is produced.

## Timing
- Cycle 0: start sampled at the rising edge while idle.
- Cycles 1..NDIG: busy = 1.
- Cycle NDIG+1: done = 1, busy = 0, results valid. Latency from start edge to done = NDIG+1 edges; NDIG=4 for the defaults.
- A start sampled during the done cycle is accepted, giving back-to-back operation. Throughput is one result per NDIG+1 cycles.
- DIGIT = WIDTH: a single RUN cycle; done occurs 2 edges after start.
- done is never asserted for two consecutive cycles.

## Test plan
- WIDTH=16, DIGIT=4, add, A=0x1234, B=0x4321, Cin=0 -> S=0x5555, Cout=0, overflow=0, zero=0; busy high 4 cycles, then done pulses 1 cycle.
- Add A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, zero=1, overflow=0. Then A=0x7FFF, B=0x0001, back-to-back on the done cycle -> S=0x8000, overflow=1, Cout=0.
- Subtract A=0x0005, B=0x0007, Cin=0 -> S=0xFFFE, Cout=0 (borrow), overflow=0. Then A=0x8000, B=0x0001, Cin=0 -> S=0x7FFF, overflow=1, Cout=1.
- Start A=0x1111, B=0x1111; pulse start again in cycle 2 with A=0xFFFF -> second start ignored, S=0x2222. Assert rst in cycle 3 of a new run -> busy=0, S=0, zero=1, no done until a new start.
- WIDTH=8, DIGIT=8, add A=0x80, B=0x80, Cin=1 -> S=0x01, Cout=1, overflow=1; done 2 edges after start.
- Randomised 1000 operations at WIDTH=12, DIGIT=3 against a behavioural A±B±Cin model. Checks S, Cout, overflow and zero.
